// File: rtl/edge_pkg.sv
// rtl/edge_pkg.sv - shared mode encodings, default counter width and edge qualification helper
package edge_pkg;

  typedef enum logic [1:0] {
    MODE_RISE = 2'b00,
    MODE_FALL = 2'b01,
    MODE_BOTH = 2'b10,
    MODE_OFF  = 2'b11
  } edge_mode_e;

  localparam int CNT_W_DEFAULT = 8;

  function automatic logic edge_qualifies(input logic [1:0] mode, input logic rising);
    logic w_ok;
    w_ok = 1'b0;
    case (edge_mode_e'(mode))
      MODE_RISE: w_ok = rising;
      MODE_FALL: w_ok = ~rising;
      MODE_BOTH: w_ok = 1'b1;
      default:   w_ok = 1'b0;
    endcase
    return w_ok;
  endfunction

endpackage

// File: rtl/edge_channel.sv
// rtl/edge_channel.sv - one channel: synchroniser, debounce, pulse, sticky flag, optional event count
// Optional event counter enabled by DEBOUNCED_EDGE_LATCH_COUNT_EN.
module edge_channel
  import edge_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_detect,
  input  logic [1:0]       i_mode,
  input  logic             i_clear,
  output logic             o_stable,
  output logic             o_pulse,
  output logic             o_flag,
  output logic             o_flag_nxt,
  output logic [CNT_W-1:0] o_count
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_stable;
  logic [DB_W-1:0]        r_db_cnt;
  logic                   r_pulse;
  logic                   r_flag;

  logic            w_synced;
  logic [DB_W-1:0] w_db_inc;
  logic            w_toggle;
  logic            w_set;
  logic            w_flag_nxt;

  assign w_synced   = r_sync[SYNC_STAGES-1];
  assign w_db_inc   = r_db_cnt + DB_W'(1);
  assign w_toggle   = (w_synced != r_stable) && (w_db_inc == DB_LAST);
  // Direction is judged from the level being left: stable low now means a rising edge.
  assign w_set      = w_toggle && edge_qualifies(i_mode, ~r_stable);
  assign w_flag_nxt = w_set | (r_flag & ~i_clear);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync   <= '0;
      r_stable <= 1'b0;
      r_db_cnt <= '0;
      r_pulse  <= 1'b0;
      r_flag   <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_detect};
      if (w_synced == r_stable) begin
        r_db_cnt <= '0;
      end else if (w_toggle) begin
        r_db_cnt <= '0;
        r_stable <= ~r_stable;
      end else begin
        r_db_cnt <= w_db_inc;
      end
      r_pulse <= w_set;
      r_flag  <= w_flag_nxt;
    end
  end

`ifdef DEBOUNCED_EDGE_LATCH_COUNT_EN
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_cnt_base;

  // Clear zeroes first, so a coincident event leaves the count at one.
  assign w_cnt_base = i_clear ? '0 : r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_set && (w_cnt_base != {CNT_W{1'b1}})) begin
      r_count <= w_cnt_base + CNT_W'(1);
    end else begin
      r_count <= w_cnt_base;
    end
  end

  assign o_count = r_count;
`else
  assign o_count = '0;
`endif

  assign o_stable   = r_stable;
  assign o_pulse    = r_pulse;
  assign o_flag     = r_flag;
  assign o_flag_nxt = w_flag_nxt;

endmodule

// File: rtl/debounced_edge_latch.sv
// rtl/debounced_edge_latch.sv - N_CH debounced edge detectors with sticky flags and registered any_flag
// Per-channel event counters enabled by DEBOUNCED_EDGE_LATCH_COUNT_EN.
module debounced_edge_latch
  import edge_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH-1:0]       detect,
  input  logic [1:0]            mode,
  input  logic [N_CH-1:0]       clear,
  output logic [N_CH-1:0]       stable,
  output logic [N_CH-1:0]       pulse,
  output logic [N_CH-1:0]       flag,
  output logic                  any_flag,
  output logic [N_CH*CNT_W-1:0] count
);

  logic [N_CH-1:0] w_flag_nxt;
  logic            r_any_flag;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    edge_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .i_detect  (detect[g]),
      .i_mode    (mode),
      .i_clear   (clear[g]),
      .o_stable  (stable[g]),
      .o_pulse   (pulse[g]),
      .o_flag    (flag[g]),
      .o_flag_nxt(w_flag_nxt[g]),
      .o_count   (count[g*CNT_W +: CNT_W])
    );
  end

  // Built from next-state flags so any_flag lines up with flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_any_flag <= 1'b0;
    end else begin
      r_any_flag <= |w_flag_nxt;
    end
  end

  assign any_flag = r_any_flag;

endmodule

// File: tb/tb_debounced_edge_latch.sv
// tb/tb_debounced_edge_latch.sv - directed bench with pulse scoreboard for debounced_edge_latch
module tb_debounced_edge_latch;

  localparam int N_CH = 4;
  localparam int SS   = 2;
  localparam int DB   = 4;
  localparam int CW   = 2;
  localparam int LAT  = SS + DB;

  logic                clk = 1'b0;
  logic                reset;
  logic [N_CH-1:0]     detect;
  logic [1:0]          mode;
  logic [N_CH-1:0]     clear;
  logic [N_CH-1:0]     stable;
  logic [N_CH-1:0]     pulse;
  logic [N_CH-1:0]     flag;
  logic                any_flag;
  logic [N_CH*CW-1:0]  count;

  debounced_edge_latch #(
    .N_CH(N_CH), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .detect(detect), .mode(mode), .clear(clear),
    .stable(stable), .pulse(pulse), .flag(flag), .any_flag(any_flag), .count(count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {int ch; int at;} exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_pulse(input int ch);
    sb.push_back('{ch: ch, at: cyc + LAT});
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int c = 0; c < N_CH; c++) begin
      if (pulse[c]) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse_ch", c, 32'hFF);
        end else begin
          e = sb.pop_front();
          chk("pulse_ch", c, e.ch);
          chk("pulse_cycle", cyc, e.at);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; detect = '0; clear = '0; mode = 2'b00;
    tick(3);
    chk("rst_stable", stable, 0);
    chk("rst_pulse", pulse, 0);
    chk("rst_flag", flag, 0);
    chk("rst_any_flag", any_flag, 0);
    chk("rst_count", count, 0);
    reset = 1'b0;
    tick(2);

    // rising edge on channel 0
    detect[0] = 1'b1; expect_pulse(0);
    tick(LAT - 1);
    chk("t1_flag_early", flag[0], 0);
    chk("t1_stable_early", stable[0], 0);
    tick(1);
    chk("t1_flag", flag[0], 1);
    chk("t1_any_flag", any_flag, 1);
    chk("t1_stable", stable[0], 1);
    tick(1);
    chk("t1_pulse_one_cycle", pulse[0], 0);
    chk("t1_flag_hold", flag[0], 1);

    // 3-cycle glitch on channel 1
    detect[1] = 1'b1; tick(3); detect[1] = 1'b0; tick(8);
    chk("t2_stable", stable[1], 0);
    chk("t2_flag", flag[1], 0);

    // clear alone, then clear coincident with a new set
    clear[0] = 1'b1; tick(1); clear[0] = 1'b0;
    chk("t3_pre_clear", flag[0], 0);
    chk("t3_pre_any", any_flag, 0);
    mode = 2'b10; detect[0] = 1'b0; expect_pulse(0);
    tick(LAT - 1); clear[0] = 1'b1; tick(1);
    chk("t3_set_wins", flag[0], 1);
    tick(1); clear[0] = 1'b0;
    chk("t3_clear_alone", flag[0], 0);
    chk("t3_any_flag", any_flag, 0);

    // falling-only mode on channel 2, then both
    mode = 2'b01; detect[2] = 1'b1; tick(10);
    chk("t4_rise_stable", stable[2], 1);
    chk("t4_rise_noflag", flag[2], 0);
    detect[2] = 1'b0; expect_pulse(2); tick(10);
    chk("t4_fall_stable", stable[2], 0);
    chk("t4_fall_flag", flag[2], 1);
    clear[2] = 1'b1; tick(1); clear[2] = 1'b0;
    mode = 2'b10; detect[2] = 1'b1; expect_pulse(2); tick(10);
    detect[2] = 1'b0; expect_pulse(2); tick(10);
    chk("t4_both_consumed", sb.size(), 0);

    // disabled mode, then a mode change after the edge
    mode = 2'b11; detect[1] = 1'b1; tick(10);
    chk("t4_off_stable", stable[1], 1);
    chk("t4_off_flag", flag[1], 0);
    mode = 2'b00; tick(5);
    chk("t4_no_retro", flag[1], 0);
    detect[1] = 1'b0; tick(10);
    chk("t4_rise_mode_fall", flag[1], 0);

    // event counting on channel 3
    mode = 2'b10; clear = '1; tick(1); clear = '0;
    for (int i = 0; i < 5; i++) begin
      detect[3] = ~detect[3]; expect_pulse(3); tick(10);
`ifdef DEBOUNCED_EDGE_LATCH_COUNT_EN
      chk("t5_count", count[7:6], (i + 1 > 3) ? 3 : i + 1);
`else
      chk("t5_count_off", count, 0);
`endif
    end
    detect[3] = 1'b0; expect_pulse(3);
    tick(LAT - 1); clear[3] = 1'b1; tick(1);
`ifdef DEBOUNCED_EDGE_LATCH_COUNT_EN
    chk("t5_inc_wins", count[7:6], 1);
`else
    chk("t5_inc_off", count, 0);
`endif
    chk("t5_flag_set", flag[3], 1);
    tick(1); clear[3] = 1'b0;
    chk("t5_count_clear", count[7:6], 0);
    chk("t5_flag_clear", flag[3], 0);

    // reset mid-debounce with input held high through release
    mode = 2'b00; detect[0] = 1'b1; tick(4);
    reset = 1'b1; tick(2);
    chk("t6_rst_stable", stable[0], 0);
    chk("t6_rst_flag", flag, 0);
    chk("t6_rst_any", any_flag, 0);
    reset = 1'b0; expect_pulse(0);
    tick(LAT - 1);
    chk("t6_flag_early", flag[0], 0);
    tick(1);
    chk("t6_flag", flag[0], 1);
    chk("t6_stable", stable[0], 1);
    chk("t6_any_flag", any_flag, 1);

    tick(10);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
